// File: rtl/tetris_timing_pkg.sv
// Shared timing definitions for the Tetris gravity path: run-state encoding,
// default divider bounds and level limits.
package tetris_timing_pkg;

    // Game run state, encoded to match the externally visible state port
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    // Level-0 bound: 0.8 s drop period at 100 MHz
    localparam int unsigned DEF_BASE_UB         = 32'd39_999_999;
    localparam int unsigned DEF_STEP_UB         = 32'd2_500_000;
    localparam int unsigned DEF_SOFT_UB         = 32'd2_499_999;
    localparam int unsigned DEF_LINES_PER_LEVEL = 32'd10;
    localparam int unsigned MAX_LEVEL           = 32'd15;

    // A single lock can clear at most four lines; larger codes are clamped
    function automatic logic [2:0] clamp_lines(input logic [2:0] raw);
        return (raw > 3'd4) ? 3'd4 : raw;
    endfunction

endpackage

// File: rtl/gravity_ctrl_level_tracker.sv
// Line and level bookkeeping for one game: running line total, lines
// accumulated toward the next level, and the saturating level counter.
module level_tracker
    import tetris_timing_pkg::*;
#(
    parameter int unsigned LINES_PER_LEVEL = DEF_LINES_PER_LEVEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        count_en,
    input  logic [2:0]  lines_cleared,
    output logic [3:0]  level,
    output logic [15:0] lines_total
);

    localparam logic [4:0] LPL  = 5'(LINES_PER_LEVEL);
    localparam logic [3:0] MAXL = 4'(MAX_LEVEL);

    logic [3:0]  lil;
    logic [2:0]  n;
    logic [16:0] total_sum;
    logic [4:0]  lil_sum;

    assign n         = clamp_lines(lines_cleared);
    assign total_sum = {1'b0, lines_total} + 17'(n);
    assign lil_sum   = {1'b0, lil} + 5'(n);

    // Accumulate cleared lines; a new game wipes everything, and since at most
    // four lines arrive per event a single subtraction handles the level-up
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lil         <= 4'd0;
            level       <= 4'd0;
            lines_total <= 16'd0;
        end else if (count_en) begin
            lines_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
            if (lil_sum >= LPL) begin
                lil <= 4'(lil_sum - LPL);
                if (level != MAXL) begin
                    level <= level + 4'd1;
                end
            end else begin
                lil <= lil_sum[3:0];
            end
        end
    end

endmodule

// File: rtl/gravity_ctrl.sv
// Gravity controller: run/pause/over state machine, level-dependent divider
// bound, and conversion of divider rising edges into one-cycle drop ticks.
module gravity_ctrl
    import tetris_timing_pkg::*;
#(
    parameter int unsigned BASE_UB         = DEF_BASE_UB,
    parameter int unsigned STEP_UB         = DEF_STEP_UB,
    parameter int unsigned SOFT_UB         = DEF_SOFT_UB,
    parameter int unsigned LINES_PER_LEVEL = DEF_LINES_PER_LEVEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        game_over,
    input  logic        soft_drop,
    input  logic        lines_valid,
    input  logic [2:0]  lines_cleared,
    input  logic        clkdiv_in,
    output logic [31:0] upperbound,
    output logic        drop_tick,
    output logic [3:0]  level,
    output logic [15:0] lines_total,
    output logic [1:0]  state
);

    state_t      state_q;
    state_t      state_d;
    logic        game_start;
    logic        in_run;
    logic        clkdiv_q;
    logic [31:0] level_ub;

    assign in_run     = (state_q == RUN);
    assign game_start = start && ((state_q == IDLE) || (state_q == OVER));
    assign level_ub   = BASE_UB - ({28'd0, level} * STEP_UB);
    assign state      = state_q;

    level_tracker #(
        .LINES_PER_LEVEL(LINES_PER_LEVEL)
    ) u_level_tracker (
        .clk          (clk),
        .rst          (rst),
        .clear        (game_start),
        .count_en     (lines_valid && in_run),
        .lines_cleared(lines_cleared),
        .level        (level),
        .lines_total  (lines_total)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; game_over outranks pause, start only matters when no game is live
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (game_over) state_d = OVER;
                     else if (pause) state_d = PAUSED;
            PAUSED:  if (game_over) state_d = OVER;
                     else if (pause) state_d = RUN;
            OVER:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Divider bound: soft drop overrides only while running, otherwise follow the level
    always_ff @(posedge clk) begin
        if (rst) begin
            upperbound <= BASE_UB;
        end else if (in_run && soft_drop) begin
            upperbound <= SOFT_UB;
        end else begin
            upperbound <= level_ub;
        end
    end

    // Rising-edge detect on the divided clock, gated by the pre-transition state
    always_ff @(posedge clk) begin
        if (rst) begin
            clkdiv_q  <= 1'b0;
            drop_tick <= 1'b0;
        end else begin
            clkdiv_q  <= clkdiv_in;
            drop_tick <= in_run && clkdiv_in && !clkdiv_q;
        end
    end

endmodule

// File: doc/gravity_ctrl.md
# gravity_ctrl

Gravity controller for the Tetris game timing path. It tracks cleared lines and the current level, and drives the `upperbound` input of the clock divider so that drop speed rises with level and during soft drop. It also consumes the divider's `clkdiv` output and turns each rising edge into a one-cycle `drop_tick` strobe for the game-logic FSM, gated by a run/pause/over state machine.

## Interface
Parameters:
- `BASE_UB`, 39_999_999: level-0 divider bound; at 100 MHz this gives a 0.8 s drop period.
- `STEP_UB`, 2_500_000: bound decrement per level.
- `SOFT_UB`, 2_499_999: bound used while soft drop is held.
- `LINES_PER_LEVEL`, 10: lines required per level-up.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; the divider runs on the same clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a new game.
- `pause`  in  1  one-cycle pulse; toggles between run and paused.
- `game_over`  in  1  one-cycle pulse from the game logic.
- `soft_drop`  in  1  level signal, held while the down key is pressed.
- `lines_valid`  in  1  one-cycle strobe qualifying `lines_cleared`.
- `lines_cleared`  in  3  lines cleared by the last lock, 0–4.
- `clkdiv_in`  in  1  divided clock from the divider, already synchronous to `clk`.
- `upperbound`  out  32  registered bound fed to the divider.
- `drop_tick`  out  1  registered one-cycle gravity strobe.
- `level`  out  4  current level, 0–15.
- `lines_total`  out  16  lines cleared this game.
- `state`  out  2  current state: IDLE=0, RUN=1, PAUSED=2, OVER=3.

## Operation
State machine:
- IDLE: `start` → RUN.
- RUN: `game_over` → OVER; otherwise `pause` → PAUSED.
- PAUSED: `game_over` → OVER; otherwise `pause` → RUN.
- OVER: `start` → RUN.
- `game_over` has priority over `pause`.
- `start` is ignored in RUN and PAUSED.

Game start (entering RUN from IDLE or OVER):
- Clears `level`, `lines_total` and the internal lines-in-level counter `lil` (0–9).

Line accounting (only when the current registered state is RUN and `lines_valid`=1):
- n = `lines_cleared`, with values above 4 treated as 4.
- `lines_total` += n, saturating at 65535.
- `lil` += n. If the sum is ≥ 10: `lil` ← sum − 10 and `level` ← `level` + 1, saturating at 15.
- Because n ≤ 4, at most one level-up can occur per event.
- At level 15, `lil` keeps wrapping while `level` holds.
- Strobes arriving in PAUSED, IDLE or OVER are dropped.

Bound selection, registered every cycle in every state:
- If state = RUN and `soft_drop`=1: `upperbound` ← `SOFT_UB`.
- Otherwise: `upperbound` ← `BASE_UB` − `level`·`STEP_UB`. This is 32-bit unsigned; at the defaults the minimum is 2_499_999 at level 15, so no underflow.

Tick generation:
- `clkdiv_q` ← `clkdiv_in` every cycle, in all states.
- `drop_tick` ← (state = RUN) & `clkdiv_in` & ~`clkdiv_q`.
- Edges that occur outside RUN are lost, not queued.

## Timing
Reset values: `state`=IDLE, `level`=0, `lines_total`=0, `lil`=0, `upperbound`=`BASE_UB`, `drop_tick`=0, `clkdiv_q`=0.

Latencies:
- `lines_valid` at edge N → new `lines_total`/`level` visible after edge N; the new `upperbound` is visible after edge N+1.
- `soft_drop` change → `upperbound` changes one cycle later.
- `clkdiv_in` low→high, sampled at edge N → `drop_tick` high for exactly the cycle after edge N.
- `pause`/`game_over` at edge N → state changes after edge N; a coincident rising edge on `clkdiv_in` still produces a tick, because gating uses the pre-transition state.

Boundary conditions:
- The divider period is 2·(`upperbound`+1) cycles.
- If the bound drops below the divider's running count, the divider toggles on its next cycle. This early tick is accepted.
- `rst` mid-game returns to IDLE next cycle with all reset values; `drop_tick` is 0 during and after reset.
- `start` coincident with `lines_valid` in OVER: the clear wins and the lines are not counted.

## Structure
- Package `tetris_timing_pkg` holds:
  - the state enum (IDLE/RUN/PAUSED/OVER);
  - defaults for `BASE_UB`, `STEP_UB`, `SOFT_UB`, `LINES_PER_LEVEL`;
  - `MAX_LEVEL`=15.
- One sub-module, `level_tracker`, owns `lil`, `level` and `lines_total`. Inputs: `clk`, `rst`, clear, `lines_valid` & run, `lines_cleared`.
- The FSM, bound register and edge detector stay in `gravity_ctrl`.
- The divider is instantiated by the parent, not inside this block.

## Test plan
- Reset, then `start`, with `clkdiv_in` toggling every 8 cycles → `state`=1, `upperbound`=39_999_999, and `drop_tick` is a single-cycle pulse every 16 cycles.
- In RUN, apply `lines_valid` with 4, 4, 3 → `lines_total` goes 4, 8, 11; `level`=1 after the third strobe; `upperbound`=37_499_999 one cycle later.
- Apply 200 strobes of 4 lines → `level` saturates at 15 and `upperbound`=2_499_999; then hold `soft_drop` → `upperbound`=2_499_999, and after release it remains 2_499_999.
- `pause` while `clkdiv_in` has rising edges → no `drop_tick` and no line counting; a second `pause` resumes ticks on the next rising edge.
- `game_over` and `pause` in the same cycle → `state`=3; a following `start` → `state`=1 with `level`=0 and `lines_total`=0.
- `rst` asserted mid-RUN at level 5 → next cycle `state`=0, `level`=0, `upperbound`=39_999_999, `drop_tick`=0.
